// File: rtl/booth_mul_arbiter.sv
// booth_mul_arbiter
//   Round-robin arbiter/sequencer sharing one multi-cycle Booth multiplier
//   among NREQ requesters. One operation is in flight at a time. The product
//   is returned with the owning requester index over a single valid/ready
//   response channel.
//
//   Optional macro BOOTH_ARB_WDOG_EN: WAIT-state watchdog. After TIMEOUT
//   cycles without mul_done the operation completes with rsp_c=0 and the
//   sticky err flag is set. Without the macro, WAIT lasts until mul_done and
//   err is tied low.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   req_valid/req_ready per-requester handshake (req_ready one-hot, IDLE only)
//   req_a/req_b         packed operands, requester i at [i*WIDTH +: WIDTH]
//   mul_a/mul_b         registered operands to the multiplier
//   mul_start           one-cycle start pulse
//   mul_done/mul_c      multiplier completion strobe and product
//   rsp_valid/rsp_ready response handshake
//   rsp_id/rsp_c        owning requester index and registered product
//   err                 sticky watchdog flag
//
// state | meaning
// IDLE  | waiting for a request; grant + operand capture happen here
// ISSUE | mul_start pulse to the multiplier
// WAIT  | waiting for mul_done (or watchdog expiry)
// RESP  | response held until rsp_ready
module booth_mul_arbiter #(
    parameter  int WIDTH   = 192,
    parameter  int NREQ    = 4,
    parameter  int TIMEOUT = 255,
    localparam int IDW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*WIDTH-1:0]  req_a,
    input  logic [NREQ*WIDTH-1:0]  req_b,
    output logic [WIDTH-1:0]       mul_a,
    output logic [WIDTH-1:0]       mul_b,
    output logic                   mul_start,
    input  logic                   mul_done,
    input  logic [2*WIDTH-1:0]     mul_c,
    output logic                   rsp_valid,
    output logic [IDW-1:0]         rsp_id,
    output logic [2*WIDTH-1:0]     rsp_c,
    input  logic                   rsp_ready,
    output logic                   err
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t         state;
    state_t         state_nxt;
    logic [IDW-1:0] last;
    logic [IDW-1:0] grant_idx;
    logic           grant_any;
    logic           wait_timeout;

    // Scan starts just after the previous winner, so a requester that keeps
    // valid high yields to any other pending requester.
    always_comb begin
        grant_idx = '0;
        grant_any = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!grant_any && req_valid[(int'(last) + k) % NREQ]) begin
                grant_any = 1'b1;
                grant_idx = IDW'((int'(last) + k) % NREQ);
            end
        end
    end

`ifdef BOOTH_ARB_WDOG_EN
    localparam int CNTW = $clog2(TIMEOUT + 1);
    logic [CNTW-1:0] wd_cnt;

    // Counter value k means k full WAIT cycles already elapsed, so expiry on
    // TIMEOUT-1 puts RESP exactly TIMEOUT cycles after entering WAIT.
    // mul_done in the expiry cycle takes priority.
    assign wait_timeout = (state == WAIT) && !mul_done &&
                          (wd_cnt == CNTW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt <= '0;
            err    <= 1'b0;
        end else begin
            if (state != WAIT)
                wd_cnt <= '0;
            else if (!mul_done)
                wd_cnt <= wd_cnt + 1'b1;
            if (wait_timeout)
                err <= 1'b1;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT == 0);
    assign wait_timeout   = 1'b0;
    assign err            = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        mul_start = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                if (grant_any) begin
                    req_ready[grant_idx] = 1'b1;
                    state_nxt            = ISSUE;
                end
            end
            ISSUE: begin
                mul_start = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (mul_done || wait_timeout)
                    state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mul_a  <= '0;
            mul_b  <= '0;
            rsp_id <= '0;
            rsp_c  <= '0;
            last   <= IDW'(NREQ - 1);
        end else begin
            if (state == IDLE && grant_any) begin
                mul_a  <= req_a[grant_idx*WIDTH +: WIDTH];
                mul_b  <= req_b[grant_idx*WIDTH +: WIDTH];
                rsp_id <= grant_idx;
            end
            if (state == WAIT) begin
                if (mul_done)
                    rsp_c <= mul_c;
                else if (wait_timeout)
                    rsp_c <= '0;
            end
            if (state == RESP && rsp_ready)
                last <= rsp_id;
        end
    end

endmodule

// File: tb/tb_booth_mul_arbiter.sv
module tb_booth_mul_arbiter;

    localparam int W   = 192;
    localparam int N   = 4;
    localparam int IDW = 2;
    localparam logic [2*W-1:0] STRAY_C = 384'hBADC0FFEE;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_a;
    logic [N*W-1:0]   req_b;
    logic [W-1:0]     mul_a;
    logic [W-1:0]     mul_b;
    logic             mul_start;
    logic             mul_done;
    logic [2*W-1:0]   mul_c;
    logic             rsp_valid;
    logic [IDW-1:0]   rsp_id;
    logic [2*W-1:0]   rsp_c;
    logic             rsp_ready;
    logic             err;

    logic             stub_done;
    logic [2*W-1:0]   stub_c;
    logic             stray_done;
    int               mul_lat = 3;
    bit               stub_en = 1'b1;

    typedef struct {
        logic [IDW-1:0] id;
        logic [2*W-1:0] c;
    } exp_t;
    exp_t exp_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign mul_done = stub_done | stray_done;
    assign mul_c    = stray_done ? STRAY_C : stub_c;

    booth_mul_arbiter #(.WIDTH(W), .NREQ(N), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .mul_a(mul_a), .mul_b(mul_b), .mul_start(mul_start),
        .mul_done(mul_done), .mul_c(mul_c),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_c(rsp_c),
        .rsp_ready(rsp_ready), .err(err)
    );

    task automatic check(input string name, input logic [2*W-1:0] act,
                         input logic [2*W-1:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [IDW-1:0] id, input logic [2*W-1:0] c);
        exp_t e;
        e.id = id;
        e.c  = c;
        exp_q.push_back(e);
    endtask

    task automatic wait_rsp_valid(input int budget, output int n);
        n = 0;
        while (!rsp_valid && n < budget) begin
            cyc();
            n++;
        end
        if (!rsp_valid) begin
            n_tests++;
            n_fail++;
            $display("FAIL rsp_wait: rsp_valid not seen within %0d cycles", budget);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_req_ready"}, req_ready, 0);
        check({tag, "_mul_start"}, mul_start, 0);
        check({tag, "_mul_a"},     mul_a, 0);
        check({tag, "_mul_b"},     mul_b, 0);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_rsp_id"},    rsp_id, 0);
        check({tag, "_rsp_c"},     rsp_c, 0);
        check({tag, "_err"},       err, 0);
    endtask

    // Multiplier stub: product of the operands seen with mul_start,
    // mul_done raised mul_lat cycles after the start cycle.
    initial begin
        logic [W-1:0] sa;
        logic [W-1:0] sb;
        stub_done = 1'b0;
        stub_c    = '0;
        forever begin
            @(negedge clk);
            if (mul_start && stub_en && !rst) begin
                sa = mul_a;
                sb = mul_b;
                repeat (mul_lat) @(posedge clk);
                #1;
                stub_c    = {{W{1'b0}}, sa} * {{W{1'b0}}, sb};
                stub_done = 1'b1;
                @(posedge clk);
                #1;
                stub_done = 1'b0;
            end
        end
    end

    // Scoreboard monitor: every accepted response pops one expectation.
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL rsp_unexpected: got id %0d c %0h expected none", rsp_id, rsp_c);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("rsp_id", rsp_id, e.id);
                check("rsp_c",  rsp_c,  e.c);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int cnt;
        int g;
        int last_g;
        int order[5];

        rst        = 1'b1;
        req_valid  = '0;
        rsp_ready  = 1'b0;
        stray_done = 1'b0;
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = W'(2 + 2*i);
            req_b[i*W +: W] = W'(3 + 2*i);
        end
        req_a[0 +: W] = W'(3);
        req_b[0 +: W] = W'(5);
        repeat (3) cyc();
        rst = 1'b0;
        check_reset_vals("reset");

        // Single request, L=191
        mul_lat   = 191;
        rsp_ready = 1'b1;
        cyc();
        req_valid = 4'b0001;
        #1;
        check("single_grant", req_ready, 4'b0001);
        push_exp(0, 15);
        cyc();
        req_valid = '0;
        check("single_start", mul_start, 1);
        check("single_mul_a", mul_a, 3);
        check("single_mul_b", mul_b, 5);
        check("single_no_ready", req_ready, 0);
        wait_rsp_valid(400, n);
        check("single_latency", n, 192);
        cyc();
        mul_lat = 3;

        // All four valid continuously after reset: 0,1,2,3,0
        req_a[0 +: W] = W'(2);
        req_b[0 +: W] = W'(3);
        rst = 1'b1;
        repeat (2) cyc();
        rst = 1'b0;
        order = '{0, 1, 2, 3, 0};
        push_exp(0, 6);
        push_exp(1, 20);
        push_exp(2, 42);
        push_exp(3, 72);
        push_exp(0, 6);
        req_valid = 4'hF;
        #1;
        cnt    = 0;
        g      = 0;
        last_g = 0;
        while (g < 5 && cnt < 200) begin
            if (req_ready != '0) begin
                check("rr_grant", req_ready, 4'b0001 << order[g]);
                if (g > 0) check("rr_period", cnt - last_g, 6);
                last_g = cnt;
                g++;
            end
            cyc();
            cnt++;
        end
        req_valid = '0;
        check("rr_grant_count", g, 5);
        cnt = 0;
        while (exp_q.size() != 0 && cnt < 100) begin
            cyc();
            cnt++;
        end
        check("rr_drain", exp_q.size(), 0);
        rsp_ready = 1'b0;

        // Back-pressure in RESP, with a stray mul_done in RESP
        req_valid = 4'b0010;
        #1;
        check("bp_grant", req_ready, 4'b0010);
        push_exp(1, 20);
        cyc();
        req_valid = '0;
        wait_rsp_valid(50, n);
        check("bp_latency", n, 4);
        req_valid = 4'hF;
        #1;
        for (int i = 0; i < 10; i++) begin
            check("bp_valid", rsp_valid, 1);
            check("bp_id", rsp_id, 1);
            check("bp_c", rsp_c, 20);
            check("bp_no_ready", req_ready, 0);
            check("bp_no_start", mul_start, 0);
            cyc();
            stray_done = (i == 3);
        end
        stray_done = 1'b0;
        rsp_ready  = 1'b1;
        req_valid  = '0;
        cyc();
        rsp_ready  = 1'b0;
        check("bp_released", rsp_valid, 0);

        // Stray mul_done in IDLE
        stray_done = 1'b1;
        cyc();
        stray_done = 1'b0;
        check("idle_stray_valid", rsp_valid, 0);
        check("idle_stray_start", mul_start, 0);
        check("idle_stray_c", rsp_c, 20);
        check("idle_stray_id", rsp_id, 1);
        check("idle_hold_mul_a", mul_a, 4);
        cyc();
        check("idle_stray_valid2", rsp_valid, 0);

        // rsp_ready pulsed in WAIT
        mul_lat   = 6;
        req_valid = 4'b0100;
        #1;
        check("wait_grant", req_ready, 4'b0100);
        push_exp(2, 42);
        cyc();
        req_valid = '0;
        cyc();
        rsp_ready = 1'b1;
        cyc();
        rsp_ready = 1'b0;
        check("wait_rdy_valid", rsp_valid, 0);
        check("wait_rdy_c", rsp_c, 20);
        check("wait_rdy_start", mul_start, 0);
        wait_rsp_valid(50, n);
        check("wait_latency", n, 5);
        rsp_ready = 1'b1;
        cyc();
        rsp_ready = 1'b0;

        // Reset during WAIT, late mul_done ignored
        mul_lat   = 10;
        req_valid = 4'b1000;
        #1;
        check("abort_grant", req_ready, 4'b1000);
        cyc();
        req_valid = '0;
        repeat (4) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check_reset_vals("abort");
        for (int i = 0; i < 15; i++) begin
            check("abort_no_valid", rsp_valid, 0);
            check("abort_no_start", mul_start, 0);
            cyc();
        end
        check_reset_vals("abort_late");
        mul_lat   = 3;
        req_valid = 4'b0100;
        #1;
        check("post_abort_grant", req_ready, 4'b0100);
        push_exp(2, 42);
        rsp_ready = 1'b1;
        cyc();
        req_valid = '0;
        wait_rsp_valid(50, n);
        cyc();
        rsp_ready = 1'b0;

`ifdef BOOTH_ARB_WDOG_EN
        // Watchdog: multiplier never answers
        stub_en   = 1'b0;
        req_valid = 4'b0001;
        #1;
        push_exp(0, 0);
        cyc();
        req_valid = '0;
        wait_rsp_valid(50, n);
        check("wdog_latency", n, 9);
        check("wdog_err", err, 1);
        rsp_ready = 1'b1;
        cyc();
        rsp_ready = 1'b0;
        stub_en   = 1'b1;
        req_valid = 4'b0010;
        #1;
        push_exp(1, 20);
        rsp_ready = 1'b1;
        cyc();
        req_valid = '0;
        wait_rsp_valid(50, n);
        check("wdog_err_sticky", err, 1);
        cyc();
        rsp_ready = 1'b0;
`endif

        repeat (5) cyc();
        check("final_drain", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
